// File: rtl/cache_set_nway.sv
// One N-way set of a write-back cache: tag lookup, byte-masked write hits, and miss handling by evict-then-refill of a victim way.
// Latency: hit/rdata are combinational in IDLE. A miss costs WORDS evict beats (only if the victim is dirty) plus WORDS refill beats.
// Backpressure: evict beats advance on evict_valid & evict_ready and refill beats on mem_valid & mem_ready. A stall holds all state.
// Build option: define CACHE_SET_PLRU_EN for tree pseudo-LRU replacement. Otherwise a round-robin pointer advances on each refill.
module cache_set_nway #(
  parameter int WAYS      = 4,
  parameter int TAG_WIDTH = 20,
  parameter int WORDS     = 4,
  localparam int WB       = $clog2(WORDS),
  localparam int WW       = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic [WB-1:0]        req_word,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_be,
  output logic                 hit,
  output logic [31:0]          rdata,
  input  logic                 refill_start,
  output logic                 busy,
  output logic                 victim_dirty,
  output logic                 evict_valid,
  input  logic                 evict_ready,
  output logic [31:0]          evict_data,
  output logic [TAG_WIDTH-1:0] evict_tag,
  output logic [WB-1:0]        evict_word,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_rdata,
  output logic                 mem_ready
);

  typedef enum logic [1:0] {IDLE, EVICT, REFILL} state_t;

  state_t                 state_q, state_d;
  logic [WAYS-1:0]        valid_q, dirty_q;
  logic [TAG_WIDTH-1:0]   tag_q [WAYS];
  logic [31:0]            data_q [WAYS][WORDS];
  logic [WB-1:0]          cnt_q;
  logic [WW-1:0]          victim_q;
  logic [TAG_WIDTH-1:0]   new_tag_q;

  logic [WAYS-1:0]        hit_vec;
  logic [WW-1:0]          hit_way, victim_c, victim_sel, pol_victim;
  logic                   any_hit, idle, wr_hit, accept, ev_fire, mem_fire, last, refill_done;

  // Tag compare across all ways. Tags are unique within the set, so at most one way matches.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w] && tag_q[w] == req_tag) begin
        hit_vec[w] = 1'b1;
        hit_way    = WW'(w);
      end
    end
  end

  // The lowest invalid way wins. Only a full set defers to the replacement policy.
  always_comb begin
    victim_c = pol_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w]) victim_c = WW'(w);
    end
  end

  assign idle        = (state_q == IDLE);
  assign any_hit     = |hit_vec;
  assign hit         = idle && req_valid && any_hit;
  assign rdata       = hit ? data_q[hit_way][req_word] : '0;
  assign wr_hit      = hit && req_write;
  assign accept      = idle && refill_start && !any_hit;
  assign last        = (cnt_q == WB'(WORDS - 1));
  assign ev_fire     = (state_q == EVICT) && evict_ready;
  assign mem_fire    = (state_q == REFILL) && mem_valid;
  assign refill_done = mem_fire && last;
  // The victim is latched once a miss is accepted, so the flag must track the latched way from then on.
  assign victim_sel   = idle ? victim_c : victim_q;
  assign victim_dirty = valid_q[victim_sel] && dirty_q[victim_sel];

`ifdef CACHE_SET_PLRU_EN
  // Heap-ordered tree: node n is stored at plru_q[n-1]. A bit of 1 means the victim lies in the right subtree.
  logic [WAYS-2:0] plru_q, plru_d;
  logic            touch_vld;
  logic [WW-1:0]   touch_way;
  int              vnode, unode;

  assign touch_vld = hit || refill_done;
  assign touch_way = hit ? hit_way : victim_q;

  // Walk the tree along the pointer bits to find the pseudo-LRU leaf.
  always_comb begin
    vnode = 1;
    for (int l = 0; l < WW; l++) vnode = 2 * vnode + int'(plru_q[vnode - 1]);
    pol_victim = WW'(vnode - WAYS);
  end

  // On each access, point every node on the used way's path away from that way.
  always_comb begin
    plru_d = plru_q;
    unode  = 1;
    if (touch_vld) begin
      for (int l = WW - 1; l >= 0; l--) begin
        plru_d[unode - 1] = ~touch_way[l];
        unode = 2 * unode + int'(touch_way[l]);
      end
    end
  end

  // Replacement-state register.
  always_ff @(posedge clk) begin
    if (reset) plru_q <= '0;
    else       plru_q <= plru_d;
  end
`else
  logic [WW-1:0] rr_q;

  assign pol_victim = rr_q;

  // The round-robin pointer advances only when a refill completes. Hits leave it alone.
  always_ff @(posedge clk) begin
    if (reset)            rr_q <= '0;
    else if (refill_done) rr_q <= rr_q + 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A dirty victim must be written back before it can be overwritten.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = victim_dirty ? EVICT : REFILL;
      EVICT:   if (ev_fire && last) state_d = REFILL;
      REFILL:  if (refill_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy        = (state_q != IDLE);
    evict_valid = (state_q == EVICT);
    mem_ready   = (state_q == REFILL);
    evict_tag   = tag_q[victim_q];
    evict_data  = data_q[victim_q][cnt_q];
    evict_word  = cnt_q;
  end

  // Control state. The counter is shared by the evict and refill streams and wraps to 0 when each phase ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      cnt_q     <= '0;
      victim_q  <= '0;
      new_tag_q <= '0;
    end else begin
      if (accept) begin
        victim_q  <= victim_c;
        new_tag_q <= req_tag;
      end
      if (wr_hit) dirty_q[hit_way] <= 1'b1;
      if (ev_fire || mem_fire) cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (refill_done) begin
        valid_q[victim_q] <= 1'b1;
        dirty_q[victim_q] <= 1'b0;
      end
    end
  end

  // Line storage (data and tags) is deliberately not reset. Validity is tracked separately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (req_be[b]) data_q[hit_way][req_word][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
      if (mem_fire)    data_q[victim_q][cnt_q] <= mem_rdata;
      if (refill_done) tag_q[victim_q]         <= new_tag_q;
    end
  end

endmodule
